// File: rtl/mips_cpu_bus_sequencer.sv
// mips_cpu_bus_sequencer
// Multi-cycle sequencer sharing the CPU's single memory port between
// instruction fetch and data load/store. Each instruction walks
// FETCH -> EXEC [-> MEM -> WB], with FETCH and MEM held on waitrequest.
// Fetching HALT_ADDR parks the CPU until reset.
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   waitrequest, readdata bus stall and read data
//   address, read, write, writedata, byteenable   bus request
//   pc                    current PC value (fetch address)
//   ctrl_mem_read/write   load/store decoded from the latched instruction
//   data_addr, data_wdata, data_be   load/store address, data and lanes
//   instr, mem_rdata      latched instruction word and load data
//   pc_en, reg_write_en   one-cycle commit pulses (EXEC or WB)
//   active                high while the CPU is running
//
// state | meaning
// IDLE  | after reset, one cycle before the first fetch
// FETCH | instruction read at pc (no read if pc is the halt address)
// EXEC  | decoder/ALU settle on instr; non-memory instructions commit
// MEM   | data load/store at data_addr
// WB    | commit of a load/store
// HALT  | terminal, left only by reset
module mips_cpu_bus_sequencer #(
   parameter logic [31:0] HALT_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        waitrequest,
   input  logic [31:0] readdata,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   output logic [31:0] writedata,
   output logic [3:0]  byteenable,
   input  logic [31:0] pc,
   input  logic        ctrl_mem_read,
   input  logic        ctrl_mem_write,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   input  logic [3:0]  data_be,
   output logic [31:0] instr,
   output logic [31:0] mem_rdata,
   output logic        pc_en,
   output logic        reg_write_en,
   output logic        active
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      EXEC  = 3'd2,
      MEM   = 3'd3,
      WB    = 3'd4,
      HALT  = 3'd5
   } state_t;

   state_t state;

   logic mem_req;
   logic mem_is_read;
   logic fetch_halt;

   assign mem_req     = ctrl_mem_read | ctrl_mem_write;
   // A store wins when both controls are raised; the read is suppressed.
   assign mem_is_read = ctrl_mem_read & ~ctrl_mem_write;
   assign fetch_halt  = (pc == HALT_ADDR);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         instr     <= 32'h0;
         mem_rdata <= 32'h0;
      end else begin
         case (state)
            IDLE:  state <= FETCH;
            FETCH: begin
               if (fetch_halt) begin
                  state <= HALT;
               end else if (!waitrequest) begin
                  instr <= readdata;
                  state <= EXEC;
               end
            end
            EXEC:  state <= mem_req ? MEM : FETCH;
            MEM: begin
               if (!waitrequest) begin
                  if (mem_is_read) mem_rdata <= readdata;
                  state <= WB;
               end
            end
            WB:    state <= FETCH;
            HALT:  state <= HALT;
            default: state <= IDLE;
         endcase
      end
   end

   // Bus and commit outputs are decoded from the state so an async reset
   // drops any in-flight strobe immediately.
   always_comb begin
      address      = 32'h0;
      read         = 1'b0;
      write        = 1'b0;
      writedata    = 32'h0;
      byteenable   = 4'h0;
      pc_en        = 1'b0;
      reg_write_en = 1'b0;
      active       = 1'b0;
      case (state)
         FETCH: begin
            active = 1'b1;
            if (!fetch_halt) begin
               address    = pc;
               read       = 1'b1;
               byteenable = 4'hF;
            end
         end
         EXEC: begin
            active       = 1'b1;
            pc_en        = ~mem_req;
            reg_write_en = ~mem_req;
         end
         MEM: begin
            active     = 1'b1;
            address    = data_addr;
            byteenable = data_be;
            writedata  = data_wdata;
            write      = ctrl_mem_write;
            read       = mem_is_read;
         end
         WB: begin
            active       = 1'b1;
            pc_en        = 1'b1;
            reg_write_en = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mips_cpu_bus_sequencer.sv
// Testbench for mips_cpu_bus_sequencer: plays the PC/decoder/memory around
// the sequencer and checks every cycle against the expected per-instruction
// timeline (fetch with stalls, exec, optional mem with stalls, write-back).
module tb_mips_cpu_bus_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        waitrequest;
   logic [31:0] readdata;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic [31:0] pc;
   logic        ctrl_mem_read;
   logic        ctrl_mem_write;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [3:0]  data_be;
   logic [31:0] instr;
   logic [31:0] mem_rdata;
   logic        pc_en;
   logic        reg_write_en;
   logic        active;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_mem_rdata;
   int pe_seen;

   mips_cpu_bus_sequencer #(.HALT_ADDR(32'h0000_0000)) dut (
      .clk(clk), .reset(reset), .waitrequest(waitrequest), .readdata(readdata),
      .address(address), .read(read), .write(write), .writedata(writedata),
      .byteenable(byteenable), .pc(pc), .ctrl_mem_read(ctrl_mem_read),
      .ctrl_mem_write(ctrl_mem_write), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_be(data_be), .instr(instr),
      .mem_rdata(mem_rdata), .pc_en(pc_en), .reg_write_en(reg_write_en),
      .active(active)
   );

   always #5 clk = ~clk;

   // {read, write, address, writedata, byteenable, pc_en, reg_write_en, active}
   function automatic logic [72:0] bus_now();
      return {read, write, address, writedata, byteenable, pc_en, reg_write_en, active};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch_phase(input logic [31:0] pcv, input logic [31:0] word, input int waits);
      logic [72:0] exp;
      pc = pcv;
      exp = {1'b1, 1'b0, pcv, 32'h0, 4'hF, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i <= waits; i++) begin
         waitrequest = (i < waits);
         readdata    = (i < waits) ? $urandom : word;
         #1;
         checks++;
         if (bus_now() !== exp) begin
            errors++;
            $display("FAIL fetch_bus pc=%h cyc=%0d: got %h want %h", pcv, i, bus_now(), exp);
         end
         step();
      end
   endtask

   task automatic exec_phase(input logic r, input logic w, input logic [31:0] word);
      logic [72:0] exp;
      ctrl_mem_read  = r;
      ctrl_mem_write = w;
      waitrequest    = 1'($urandom);
      readdata       = $urandom;
      #1;
      exp = {1'b0, 1'b0, 32'h0, 32'h0, 4'h0, ~(r | w), ~(r | w), 1'b1};
      checks++;
      if (bus_now() !== exp) begin
         errors++;
         $display("FAIL exec_bus: got %h want %h", bus_now(), exp);
      end
      checks++;
      if (instr !== word) begin
         errors++;
         $display("FAIL exec_instr: got %h want %h", instr, word);
      end
      checks++;
      if (mem_rdata !== exp_mem_rdata) begin
         errors++;
         $display("FAIL exec_mem_rdata: got %h want %h", mem_rdata, exp_mem_rdata);
      end
      pe_seen += int'(pc_en);
      step();
   endtask

   task automatic mem_phase(input logic r, input logic w, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be,
                            input int waits, input logic [31:0] ldata);
      logic [72:0] exp;
      data_addr  = addr;
      data_wdata = wdata;
      data_be    = be;
      exp = {r & ~w, w, addr, wdata, be, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i <= waits; i++) begin
         waitrequest = (i < waits);
         readdata    = (i < waits) ? $urandom : ldata;
         #1;
         checks++;
         if (bus_now() !== exp) begin
            errors++;
            $display("FAIL mem_bus cyc=%0d: got %h want %h", i, bus_now(), exp);
         end
         pe_seen += int'(pc_en);
         step();
      end
      if (r && !w) exp_mem_rdata = ldata;
   endtask

   task automatic wb_phase();
      logic [72:0] exp;
      waitrequest = 1'($urandom);
      readdata    = $urandom;
      #1;
      exp = {1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b1};
      checks++;
      if (bus_now() !== exp) begin
         errors++;
         $display("FAIL wb_bus: got %h want %h", bus_now(), exp);
      end
      checks++;
      if (mem_rdata !== exp_mem_rdata) begin
         errors++;
         $display("FAIL wb_mem_rdata: got %h want %h", mem_rdata, exp_mem_rdata);
      end
      pe_seen += int'(pc_en);
      step();
   endtask

   task automatic run_instr(input logic [31:0] pcv, input logic [31:0] word,
                            input logic r, input logic w, input int fw, input int mw,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, input logic [31:0] ldata);
      pe_seen = 0;
      fetch_phase(pcv, word, fw);
      exec_phase(r, w, word);
      if (r || w) begin
         mem_phase(r, w, addr, wdata, be, mw, ldata);
         wb_phase();
      end
      checks++;
      if (pe_seen != 1) begin
         errors++;
         $display("FAIL pc_en_pulses pc=%h: got %0d want 1", pcv, pe_seen);
      end
   endtask

   task automatic test_reset();
      reset          = 1'b1;
      waitrequest    = 1'b0;
      readdata       = $urandom;
      pc             = 32'hBFC0_0000;
      ctrl_mem_read  = 1'b0;
      ctrl_mem_write = 1'b0;
      data_addr      = $urandom;
      data_wdata     = $urandom;
      data_be        = 4'hF;
      exp_mem_rdata  = 32'h0;
      step();
      step();
      checks++;
      if ({bus_now(), instr, mem_rdata} !== {73'h0, 32'h0, 32'h0}) begin
         errors++;
         $display("FAIL reset_held: got bus=%h instr=%h mem_rdata=%h want all zero",
                  bus_now(), instr, mem_rdata);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (bus_now() !== 73'h0) begin
         errors++;
         $display("FAIL reset_idle: got %h want 0", bus_now());
      end
      step();
   endtask

   task automatic test_first_fetch();
      run_instr(32'hBFC0_0000, 32'h2408_0001, 1'b0, 1'b0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0);
   endtask

   task automatic test_lw_stall();
      run_instr(32'hBFC0_0004, 32'h8C08_1000, 1'b1, 1'b0, 1, 3,
                32'h0000_1000, 32'h0, 4'hF, 32'hDEAD_BEEF);
   endtask

   task automatic test_sb();
      run_instr(32'hBFC0_0008, 32'hA008_1002, 1'b0, 1'b1, 0, 0,
                32'h0000_1002, 32'h00AB_0000, 4'b0100, 32'h1234_5678);
   endtask

   task automatic test_both_controls();
      run_instr(32'hBFC0_000C, 32'hFFFF_0000, 1'b1, 1'b1, 2, 1,
                32'h0000_2000, 32'hCAFE_F00D, 4'b0011, 32'h5555_AAAA);
   endtask

   task automatic test_reset_mid();
      logic [72:0] exp;
      pe_seen = 0;
      fetch_phase(32'h8000_0100, 32'h8C09_2000, 0);
      exec_phase(1'b1, 1'b0, 32'h8C09_2000);
      data_addr   = 32'h0000_2000;
      data_be     = 4'hF;
      waitrequest = 1'b1;
      readdata    = $urandom;
      #1;
      exp = {1'b1, 1'b0, 32'h0000_2000, data_wdata, 4'hF, 1'b0, 1'b0, 1'b1};
      checks++;
      if (bus_now() !== exp) begin
         errors++;
         $display("FAIL midreset_mem: got %h want %h", bus_now(), exp);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({read, write, active, instr, mem_rdata} !== {3'b000, 32'h0, 32'h0}) begin
         errors++;
         $display("FAIL midreset_drop: got r=%b w=%b act=%b instr=%h mem_rdata=%h want zeros",
                  read, write, active, instr, mem_rdata);
      end
      step();
      step();
      checks++;
      if ({bus_now(), instr} !== {73'h0, 32'h0}) begin
         errors++;
         $display("FAIL midreset_held: got bus=%h instr=%h want zeros", bus_now(), instr);
      end
      reset = 1'b0;
      exp_mem_rdata = 32'h0;
      #1;
      checks++;
      if (bus_now() !== 73'h0) begin
         errors++;
         $display("FAIL midreset_idle: got %h want 0", bus_now());
      end
      step();
      run_instr(32'h8000_0100, 32'h0000_0021, 1'b0, 1'b0, 1, 0, 32'h0, 32'h0, 4'h0, 32'h0);
   endtask

   task automatic test_random();
      int k;
      logic r, w;
      logic [31:0] pcv;
      for (int n = 0; n < 40; n++) begin
         k   = $urandom_range(0, 3);
         r   = (k == 1) || (k == 3);
         w   = (k >= 2);
         pcv = $urandom | 32'h4;
         run_instr(pcv, $urandom, r, w, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom, $urandom, 4'($urandom), $urandom);
      end
   endtask

   task automatic test_halt();
      logic [72:0] exp;
      run_instr(32'h8000_0200, 32'h03E0_0008, 1'b0, 1'b0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0);
      pc          = 32'h0;
      waitrequest = 1'($urandom);
      readdata    = $urandom;
      #1;
      exp = {1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1};
      checks++;
      if (bus_now() !== exp) begin
         errors++;
         $display("FAIL halt_fetch: got %h want %h", bus_now(), exp);
      end
      step();
      for (int i = 0; i < 20; i++) begin
         waitrequest    = 1'($urandom);
         readdata       = $urandom;
         ctrl_mem_read  = 1'($urandom);
         ctrl_mem_write = 1'($urandom);
         pc             = (i < 10) ? 32'h0 : $urandom;
         #1;
         checks++;
         if (bus_now() !== 73'h0) begin
            errors++;
            $display("FAIL halt_parked cyc=%0d: got %h want 0", i, bus_now());
         end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_first_fetch();
      test_lw_stall();
      test_sb();
      test_both_controls();
      test_reset_mid();
      test_random();
      test_halt();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
